rgb_to_gray_stream: RTL and testbench

- Converts a 24-bit RGB AXI4-Stream video feed into an 8-bit luma (greyscale) stream.
- Sits directly upstream of the histogram-equalisation stage and feeds its s_axis input.
- Uses a 3-stage, fully back-pressurable pipeline. tuser (start of frame) and tlast (end of line) are carried through aligned with the pixel they belong to.

---
 rtl/rgb_to_gray_stream.sv | 95 +++++++++
 tb/tb_rgb_to_gray_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray_stream.sv
// RGB to luma converter for AXI4-Stream video: Y = (R*cr + G*cg + B*cb + 128) >> 8.
// Three back-pressurable stages (products, rounded sum, shift) with tuser/tlast riding alongside.
module rgb_to_gray_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_R     = 77,
  parameter int COEF_G     = 150,
  parameter int COEF_B     = 29
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_aresetn,
  input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);
  localparam int PROD_W = DATA_WIDTH + 8;
  localparam int SUM_W  = DATA_WIDTH + 10;
  localparam logic [7:0]       CR    = 8'(COEF_R);
  localparam logic [7:0]       CG    = 8'(COEF_G);
  localparam logic [7:0]       CB    = 8'(COEF_B);
  localparam logic [SUM_W-1:0] ROUND = SUM_W'(128);

  if (COEF_R + COEF_G + COEF_B != 256) begin : g_coef_check
    $error("rgb_to_gray_stream: COEF_R + COEF_G + COEF_B must equal 256");
  end

  logic [DATA_WIDTH-1:0] comp_r, comp_g, comp_b;
  assign comp_g = s_axis_tdata[DATA_WIDTH-1:0];
  assign comp_b = s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign comp_r = s_axis_tdata[3*DATA_WIDTH-1:2*DATA_WIDTH];

  logic [PROD_W-1:0]     p_r, p_g, p_b;
  logic                  v1, u1, l1;
  logic [SUM_W-1:0]      sum2;
  logic                  v2, u2, l2;
  logic [DATA_WIDTH-1:0] y3;
  logic                  v3, u3, l3;
  logic                  ready_en;
  logic                  r1, r2, r3;

  // Handshake: a beat moves on an edge where valid & ready are both high; valid never waits on
  // ready, and each stage loads whenever it is empty or its successor is moving on this cycle.
  assign r3 = !v3 | m_axis_tready;
  assign r2 = !v2 | r3;
  assign r1 = !v1 | r2;
  // ready_en holds tready low through reset and for the first edge after release.
  assign s_axis_tready = r1 & ready_en;

  assign m_axis_tdata  = y3;
  assign m_axis_tvalid = v3;
  assign m_axis_tuser  = u3;
  assign m_axis_tlast  = l3;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      ready_en <= 1'b0;
      v1 <= 1'b0; u1 <= 1'b0; l1 <= 1'b0;
      p_r <= '0; p_g <= '0; p_b <= '0;
      v2 <= 1'b0; u2 <= 1'b0; l2 <= 1'b0;
      sum2 <= '0;
      v3 <= 1'b0; u3 <= 1'b0; l3 <= 1'b0;
      y3 <= '0;
    end else begin
      ready_en <= 1'b1;
      if (r1) begin
        v1 <= s_axis_tvalid & ready_en;
        u1 <= s_axis_tuser;
        l1 <= s_axis_tlast;
      end
      if (r1 && s_axis_tvalid) begin
        p_r <= {8'b0, comp_r} * {{DATA_WIDTH{1'b0}}, CR};
        p_g <= {8'b0, comp_g} * {{DATA_WIDTH{1'b0}}, CG};
        p_b <= {8'b0, comp_b} * {{DATA_WIDTH{1'b0}}, CB};
      end
      if (r2) begin
        v2 <= v1;
        u2 <= u1;
        l2 <= l1;
        if (v1) sum2 <= {2'b0, p_r} + {2'b0, p_g} + {2'b0, p_b} + ROUND;
      end
      if (r3) begin
        v3 <= v2;
        u3 <= u2;
        l3 <= l2;
        if (v2) y3 <= sum2[SUM_W-3:8];
      end
    end
  end
endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream: reset, primaries with latency, streaming,
// backpressure, random handshakes and mid-stream reset, backed by an ordered scoreboard.
module tb_rgb_to_gray_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_data;
  logic        s_valid, s_user, s_last, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_user, m_last, m_ready;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];  // {tuser, tlast, luma}
  logic [9:0] sb_e;

  always #5 clk = ~clk;

  rgb_to_gray_stream dut (
    .i_sys_clk     (clk),
    .i_sys_aresetn (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tuser  (s_user),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tuser  (m_user),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready)
  );

  function automatic logic [7:0] luma(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]);
    b = int'(rgb[15:8]);
    g = int'(rgb[7:0]);
    return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs are pushed on handshake, outputs popped and compared in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected: observed output %0h expected no output", m_data);
        end
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          check("sb_data", {22'b0, m_user, m_last, m_data}, {22'b0, sb_e});
        end
      end
      if (s_valid && s_ready) exp_q.push_back({s_user, s_last, luma(s_data)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_lat(input logic [23:0] rgb, input logic [7:0] exp, input string tag);
    @(posedge clk); #1;
    s_data = rgb; s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0;
    @(negedge clk); check({tag, "_rdy"}, s_ready, 1);
    @(posedge clk); #1 s_valid = 1'b0;
    @(negedge clk); check({tag, "_lat1"}, m_valid, 0);
    @(negedge clk); check({tag, "_lat2"}, m_valid, 0);
    @(negedge clk); check({tag, "_lat3"}, m_valid, 1);
    check({tag, "_data"}, m_data, exp);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_empty"}, m_valid, 0);
  endtask

  logic [23:0] bp_pix [4];
  int          idx;
  logic [7:0]  held;
  logic        seen, acc;

  initial begin
    bp_pix = '{24'h102030, 24'hA0B0C0, 24'h5A5A5A, 24'hFF8000};
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; m_ready = 1'b1;

    // reset state and tready release
    repeat (2) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_user", m_user, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    #1 check("rel_s_ready_early", s_ready, 0);
    @(posedge clk); #1 check("rel_s_ready", s_ready, 1);

    // primaries and mixed pixel
    send_lat(24'hFFFFFF, 8'hFF, "white");
    send_lat(24'h000000, 8'h00, "black");
    send_lat(24'hFF0000, 8'd77, "red");
    send_lat(24'h0000FF, 8'd149, "green");
    send_lat(24'h00FF00, 8'd29, "blue");
    send_lat(24'h64C832, 8'h52, "mixed");

    // 16 back-to-back pixels: pixel j is visible at the negedge of iteration j+3
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (j < 16) begin
        s_valid = 1'b1;
        s_data  = {8'(j * 17), 8'(255 - j * 13), 8'(j * 5 + 3)};
        s_user  = (j == 0);
        s_last  = (j == 15);
      end else begin
        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
      end
      @(negedge clk);
      if (j < 16) check("stream_rdy", s_ready, 1);
      check("stream_valid", m_valid, (j >= 3 && j < 19));
      if (j >= 3 && j < 19) begin
        check("stream_user", m_user, (j == 3));
        check("stream_last", m_last, (j == 18));
      end
    end
    drain("stream");

    // backpressure: exactly three accepted, output frozen while stalled
    m_ready = 1'b0; idx = 0; seen = 1'b0; held = '0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = bp_pix[idx]; s_user = 1'b0; s_last = 1'b0;
      @(negedge clk);
      if (s_ready) idx++;
      if (m_valid) begin
        if (!seen) begin
          held = m_data; seen = 1'b1;
        end else begin
          check("bp_stable", m_data, held);
        end
      end
    end
    check("bp_accepted", idx, 3);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_head", held, 8'd37);
    @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
    drain("bp");

    // random valid/ready, AXI-legal source (payload held until accepted)
    for (int j = 0; j < 300; j++) begin
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc || !s_valid) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 24'($urandom);
        s_user  = 1'($urandom_range(0, 1));
        s_last  = 1'($urandom_range(0, 1));
      end
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 s_valid = 1'b0;
    drain("rand");

    // reset with three pixels in flight
    m_ready = 1'b0; idx = 0;
    for (int j = 0; j < 8 && idx < 3; j++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = bp_pix[idx]; s_user = (idx == 0); s_last = 1'b0;
      @(negedge clk);
      if (s_ready) idx++;
    end
    @(posedge clk); #1 s_valid = 1'b0; s_user = 1'b0;
    check("mrst_loaded", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_m_valid", m_valid, 0);
    check("mrst_m_data", m_data, 0);
    check("mrst_m_user", m_user, 0);
    check("mrst_s_ready", s_ready, 0);
    exp_q.delete();
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("mrst_no_stale", m_valid, 0);
    end
    send_lat(24'h64C832, 8'h52, "post_rst");
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
